// File: rtl/demux_dest.sv
// Routing stage ahead of fifo_d0/fifo_d1: pops a VC word, holds it, pushes it to the FIFO picked by bit DEST_BIT.
// Optional per-destination push counters are enabled with `define DEMUX_STATS_EN.
module demux_dest #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 vc_empty,
  input  logic [DATA_SIZE-1:0] vc_data,
  output logic                 pop_vc,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]           cnt_d0,
  output logic [7:0]           cnt_d1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [DATA_SIZE-1:0] hold_reg;
  logic                 dest;
  logic                 fire;

  assign dest    = hold_reg[DEST_BIT];
  assign fire    = dest ? !fifo_pause_d1 : !fifo_pause_d0;
  assign data_d0 = hold_reg;
  assign data_d1 = hold_reg;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = vc_empty ? IDLE : WAIT;
      WAIT: next_state = HOLD;
      HOLD: begin
        if (fire) begin
          next_state = vc_empty ? IDLE : WAIT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are gated by reset_L so nothing leaks out while reset is held low.
  always_comb begin
    pop_vc  = 1'b0;
    push_d0 = 1'b0;
    push_d1 = 1'b0;
    if (reset_L) begin
      case (state)
        IDLE: pop_vc = !vc_empty;
        HOLD: begin
          push_d0 = fire & !dest;
          push_d1 = fire & dest;
          pop_vc  = fire & !vc_empty;
        end
        default: begin
          pop_vc  = 1'b0;
          push_d0 = 1'b0;
          push_d1 = 1'b0;
        end
      endcase
    end
  end

  // The VC FIFO registers its read data, so the word is captured one cycle after the pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hold_reg <= '0;
    end else if (state == WAIT) begin
      hold_reg <= vc_data;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_d0 <= 8'd0;
      cnt_d1 <= 8'd0;
    end else begin
      if (push_d0) cnt_d0 <= cnt_d0 + 8'd1;
      if (push_d1) cnt_d1 <= cnt_d1 + 8'd1;
    end
  end
`endif

endmodule
